// File: rtl/sr_flip_flop_if.sv
// ----------------------------------------------------------------------------
// sr_flip_flop_if
// Purpose : Bundles the set/reset requests and the stored-state outputs of an
//           sr_flip_flop bank so the cell can be connected with one port.
// Signals : s      per-bit set request         (master -> slave)
//           r      per-bit reset request       (master -> slave)
//           q      stored state                (slave  -> master)
//           q_bar  complement of q             (slave  -> master)
//           both   s&r seen at the last edge   (slave  -> master)
// Modports: master drives s/r and observes q/q_bar/both; slave is the flip-flop.
// ----------------------------------------------------------------------------
interface sr_flip_flop_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic [WIDTH-1:0] both;

    modport master (
        output s,
        output r,
        input  q,
        input  q_bar,
        input  both
    );

    modport slave (
        input  s,
        input  r,
        output q,
        output q_bar,
        output both
    );
endinterface

// File: rtl/sr_flip_flop.sv
// ----------------------------------------------------------------------------
// sr_flip_flop
// Purpose : Bank of WIDTH independent rising-edge SR flip-flops with true and
//           complementary outputs, a programmable policy for the S=R=1 case
//           and a per-bit registered flag raised when S=R=1 was captured.
// Params  : WIDTH      number of independent bits
//           RESET_VAL  value loaded into every bit of q during reset
//           BOTH_MODE  S=R=1 policy: 0 hold, 1 set, 2 reset, 3 toggle
//                      (any other value behaves as hold)
// Ports   : clk    rising-edge clock
//           reset  asynchronous active-low reset (0 = asserted)
//           bus    sr_flip_flop_if slave: s, r in; q, q_bar, both out
// ----------------------------------------------------------------------------
module sr_flip_flop #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b0,
    parameter int   BOTH_MODE = 0
) (
    input  logic            clk,
    input  logic            reset,
    sr_flip_flop_if.slave   bus
);

    // Out-of-range policy values collapse to hold so S=R=1 is always defined.
    localparam int MODE = ((BOTH_MODE >= 0) && (BOTH_MODE <= 3)) ? BOTH_MODE : 0;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] both_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic q_bit_reg;
            logic q_bit_next;
            logic both_bit_reg;
            logic both_bit_next;

            always_comb begin
                q_bit_next    = q_bit_reg;
                both_bit_next = bus.s[gi] & bus.r[gi];
                unique case ({bus.s[gi], bus.r[gi]})
                    2'b00: q_bit_next = q_bit_reg;
                    2'b01: q_bit_next = 1'b0;
                    2'b10: q_bit_next = 1'b1;
                    2'b11: begin
                        case (MODE)
                            1:       q_bit_next = 1'b1;
                            2:       q_bit_next = 1'b0;
                            3:       q_bit_next = ~q_bit_reg;
                            default: q_bit_next = q_bit_reg;
                        endcase
                    end
                    default: q_bit_next = q_bit_reg;
                endcase
            end

            // Reset overrides any pending s/r the moment it asserts.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q_bit_reg    <= RESET_VAL;
                    both_bit_reg <= 1'b0;
                end else begin
                    q_bit_reg    <= q_bit_next;
                    both_bit_reg <= both_bit_next;
                end
            end

            assign q_reg[gi]    = q_bit_reg;
            assign both_reg[gi] = both_bit_reg;
        end
    endgenerate

    // q_bar is derived, not stored, so it can never disagree with q.
    assign bus.q     = q_reg;
    assign bus.q_bar = ~q_reg;
    assign bus.both  = both_reg;

endmodule

// File: tb/tb_sr_flip_flop.sv
module tb_sr_flip_flop;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    sr_flip_flop_if #(.WIDTH(1)) bus0 ();
    sr_flip_flop_if #(.WIDTH(1)) bus1 ();
    sr_flip_flop_if #(.WIDTH(1)) bus2 ();
    sr_flip_flop_if #(.WIDTH(1)) bus3 ();
    sr_flip_flop_if #(.WIDTH(1)) bus5 ();
    sr_flip_flop_if #(.WIDTH(4)) bus4 ();

    sr_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    sr_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));
    sr_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_MODE(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));
    sr_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_MODE(3)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave));
    sr_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_MODE(5)) u_dut5 (
        .clk(clk), .reset(reset), .bus(bus5.slave));
    sr_flip_flop #(.WIDTH(4), .RESET_VAL(1'b1), .BOTH_MODE(0)) u_dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_all();
        bus0.s = 1'b0; bus0.r = 1'b0;
        bus1.s = 1'b0; bus1.r = 1'b0;
        bus2.s = 1'b0; bus2.r = 1'b0;
        bus3.s = 1'b0; bus3.r = 1'b0;
        bus5.s = 1'b0; bus5.r = 1'b0;
        bus4.s = 4'b0000; bus4.r = 4'b0000;
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1'b0;
        edge_step();
        edge_step();
        checks++;
        if (bus0.q !== 1'b0 || bus0.q_bar !== 1'b1 || bus0.both !== 1'b0) begin
            errors++;
            $display("FAIL reset_w1: q=%b q_bar=%b both=%b expected q=0 q_bar=1 both=0",
                     bus0.q, bus0.q_bar, bus0.both);
        end
        checks++;
        if (bus4.q !== 4'b1111 || bus4.q_bar !== 4'b0000 || bus4.both !== 4'b0000) begin
            errors++;
            $display("FAIL reset_w4: q=%b q_bar=%b both=%b expected q=1111 q_bar=0000 both=0000",
                     bus4.q, bus4.q_bar, bus4.both);
        end
        reset = 1'b1;
        bus0.s = 1'b1;
        edge_step();
        bus0.s = 1'b0;
        checks++;
        if (bus0.q !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_set: q=%b expected 1", bus0.q);
        end
        // Pulse reset between edges; q must clear without a clock edge.
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (bus0.q !== 1'b0 || bus0.q_bar !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: q=%b q_bar=%b expected q=0 q_bar=1", bus0.q, bus0.q_bar);
        end
        reset = 1'b1;
        edge_step();
        $display("test_reset done");
    endtask

    task automatic test_set_reset();
        bus0.s = 1'b0; bus0.r = 1'b1;
        edge_step();
        checks++;
        if (bus0.q !== 1'b0 || bus0.q_bar !== 1'b1) begin
            errors++;
            $display("FAIL sr_reset: q=%b q_bar=%b expected q=0 q_bar=1", bus0.q, bus0.q_bar);
        end
        bus0.s = 1'b1; bus0.r = 1'b0;
        edge_step();
        checks++;
        if (bus0.q !== 1'b1 || bus0.q_bar !== 1'b0) begin
            errors++;
            $display("FAIL sr_set: q=%b q_bar=%b expected q=1 q_bar=0", bus0.q, bus0.q_bar);
        end
        bus0.s = 1'b0; bus0.r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            checks++;
            if (bus0.q !== 1'b1) begin
                errors++;
                $display("FAIL sr_hold edge %0d: q=%b expected 1", i, bus0.q);
            end
        end
        $display("test_set_reset done");
    endtask

    task automatic test_both_hold();
        bus0.s = 1'b1; bus0.r = 1'b1;
        edge_step();
        checks++;
        if (bus0.q !== 1'b1 || bus0.q_bar !== 1'b0 || bus0.both !== 1'b1) begin
            errors++;
            $display("FAIL both_hold: q=%b q_bar=%b both=%b expected q=1 q_bar=0 both=1",
                     bus0.q, bus0.q_bar, bus0.both);
        end
        bus0.s = 1'b0; bus0.r = 1'b0;
        edge_step();
        checks++;
        if (bus0.both !== 1'b0 || bus0.q !== 1'b1) begin
            errors++;
            $display("FAIL both_clear: both=%b q=%b expected both=0 q=1", bus0.both, bus0.q);
        end
        $display("test_both_hold done");
    endtask

    task automatic test_both_modes();
        logic [1:0] exp1;
        logic [1:0] exp2;
        logic [1:0] exp3;
        logic [1:0] exp5;
        exp1 = 2'b11; exp2 = 2'b00; exp3 = 2'b01; exp5 = 2'b00;
        bus1.r = 1'b1; bus2.r = 1'b1; bus3.r = 1'b1; bus5.r = 1'b1;
        edge_step();
        bus1.s = 1'b1; bus2.s = 1'b1; bus3.s = 1'b1; bus5.s = 1'b1;
        for (int i = 0; i < 2; i++) begin
            edge_step();
            // exp vectors hold edge 0 in bit 0, edge 1 in bit 1
            checks++;
            if (bus1.q !== exp1[i] || bus1.both !== 1'b1) begin
                errors++;
                $display("FAIL mode1 edge %0d: q=%b both=%b expected q=%b both=1",
                         i, bus1.q, bus1.both, exp1[i]);
            end
            checks++;
            if (bus2.q !== exp2[i] || bus2.both !== 1'b1) begin
                errors++;
                $display("FAIL mode2 edge %0d: q=%b both=%b expected q=%b both=1",
                         i, bus2.q, bus2.both, exp2[i]);
            end
            checks++;
            if (bus3.q !== exp3[i] || bus3.q_bar !== ~exp3[i] || bus3.both !== 1'b1) begin
                errors++;
                $display("FAIL mode3 edge %0d: q=%b q_bar=%b both=%b expected q=%b",
                         i, bus3.q, bus3.q_bar, bus3.both, exp3[i]);
            end
            checks++;
            if (bus5.q !== exp5[i] || bus5.both !== 1'b1) begin
                errors++;
                $display("FAIL mode_illegal edge %0d: q=%b both=%b expected q=%b both=1",
                         i, bus5.q, bus5.both, exp5[i]);
            end
        end
        // Illegal mode must hold a 1 as well as a 0.
        bus5.s = 1'b1; bus5.r = 1'b0;
        edge_step();
        bus5.r = 1'b1;
        edge_step();
        checks++;
        if (bus5.q !== 1'b1) begin
            errors++;
            $display("FAIL mode_illegal_hold1: q=%b expected 1", bus5.q);
        end
        idle_all();
        edge_step();
        $display("test_both_modes done");
    endtask

    task automatic test_mid_reset();
        bus4.s = 4'b0000; bus4.r = 4'b1111;
        edge_step();
        checks++;
        if (bus4.q !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_pre: q=%b expected 0000", bus4.q);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (bus4.q !== 4'b1111 || bus4.q_bar !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_async: q=%b q_bar=%b expected q=1111 q_bar=0000",
                     bus4.q, bus4.q_bar);
        end
        edge_step();
        checks++;
        if (bus4.q !== 4'b1111 || bus4.both !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_held: q=%b both=%b expected q=1111 both=0000",
                     bus4.q, bus4.both);
        end
        reset = 1'b1;
        edge_step();
        checks++;
        if (bus4.q !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_release: q=%b expected 0000", bus4.q);
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_independence();
        bus4.s = 4'b1010; bus4.r = 4'b0101;
        edge_step();
        checks++;
        if (bus4.q !== 4'b1010 || bus4.q_bar !== 4'b0101 || bus4.both !== 4'b0000) begin
            errors++;
            $display("FAIL indep_a: q=%b q_bar=%b both=%b expected q=1010 q_bar=0101 both=0000",
                     bus4.q, bus4.q_bar, bus4.both);
        end
        bus4.s = 4'b0110; bus4.r = 4'b0011;
        edge_step();
        // bit3 hold 1, bit2 set 1, bit1 both->hold 1, bit0 reset 0
        checks++;
        if (bus4.q !== 4'b1110 || bus4.both !== 4'b0010) begin
            errors++;
            $display("FAIL indep_b: q=%b both=%b expected q=1110 both=0010",
                     bus4.q, bus4.both);
        end
        bus4.s = 4'b0101; bus4.r = 4'b1010;
        edge_step();
        checks++;
        if (bus4.q !== 4'b0101 || bus4.q_bar !== 4'b1010 || bus4.both !== 4'b0000) begin
            errors++;
            $display("FAIL indep_c: q=%b q_bar=%b both=%b expected q=0101 q_bar=1010 both=0000",
                     bus4.q, bus4.q_bar, bus4.both);
        end
        idle_all();
        $display("test_independence done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idle_all();
        test_reset();
        test_set_reset();
        test_both_hold();
        test_both_modes();
        test_mid_reset();
        test_independence();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
